// File: rtl/fsm_response_checker.sv
// Response checker: stores expected fsm output vectors, then compares a sampled
// dut_out stream against them, counting mismatches and folding samples into a MISR.
module fsm_response_checker #(
  parameter int                 OUT_LEN = 19,
  parameter int                 DEPTH   = 125,
  parameter int                 IDX_W   = 7,
  parameter logic [OUT_LEN-1:0] POLY    = 19'h00027
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [OUT_LEN-1:0] load_data,
  input  logic               start,
  input  logic               dut_valid,
  input  logic [OUT_LEN-1:0] dut_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [IDX_W-1:0]   mismatch_cnt,
  output logic [IDX_W-1:0]   first_fail_idx,
  output logic               first_fail_vld,
  output logic [IDX_W-1:0]   load_cnt,
  output logic               ovf,
  output logic [OUT_LEN-1:0] signature
);

  localparam logic [IDX_W-1:0] DEPTH_C = IDX_W'(DEPTH);
  localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     load_cnt_q, load_cnt_d;
  logic [IDX_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]     mm_cnt_q, mm_cnt_d;
  logic [IDX_W-1:0]     ff_idx_q, ff_idx_d;
  logic                 ff_vld_q, ff_vld_d;
  logic                 ovf_q, ovf_d;
  logic [OUT_LEN-1:0]   sig_q, sig_d;

  // Expected vectors are not reset; load_cnt = 0 makes them unreachable.
  logic [OUT_LEN-1:0]   mem [DEPTH];

  logic can_load, load_req, full, mem_we, run_start, sample, last, miss;

  assign can_load  = (state_q == IDLE) || (state_q == LOAD);
  assign load_req  = can_load && load_en;
  assign full      = (load_cnt_q == DEPTH_C);
  assign mem_we    = load_req && !full;
  // A load in the same cycle wins over start.
  assign run_start = start && ((can_load && !load_en && (load_cnt_q != '0)) ||
                               (state_q == RUN) || (state_q == DONE));
  assign sample    = (state_q == RUN) && dut_valid && !start;
  assign last      = (rd_ptr_q == (load_cnt_q - ONE));
  assign miss      = (mem[rd_ptr_q] != dut_out);

  always_ff @(posedge clk) begin
    if (mem_we) mem[load_cnt_q] <= load_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, LOAD: if (load_en) state_d = LOAD;
                  else if (run_start) state_d = RUN;
      RUN:        if (sample && last) state_d = DONE;
      DONE:       if (start) state_d = RUN;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    pass = (state_q == DONE) && (mm_cnt_q == '0);
  end

  always_comb begin
    load_cnt_d = load_cnt_q;
    ovf_d      = ovf_q;
    rd_ptr_d   = rd_ptr_q;
    mm_cnt_d   = mm_cnt_q;
    ff_idx_d   = ff_idx_q;
    ff_vld_d   = ff_vld_q;
    sig_d      = sig_q;
    if (mem_we)          load_cnt_d = load_cnt_q + ONE;
    if (load_req && full) ovf_d     = 1'b1;
    if (run_start) begin
      rd_ptr_d = '0;
      mm_cnt_d = '0;
      ff_idx_d = '0;
      ff_vld_d = 1'b0;
      sig_d    = '0;
    end else if (sample) begin
      // Pointer parks on the final entry so it never indexes past the table.
      rd_ptr_d = last ? rd_ptr_q : rd_ptr_q + ONE;
      sig_d    = {sig_q[OUT_LEN-2:0], 1'b0} ^ (sig_q[OUT_LEN-1] ? POLY : '0) ^ dut_out;
      if (miss) begin
        mm_cnt_d = mm_cnt_q + ONE;
        if (!ff_vld_q) begin
          ff_idx_d = rd_ptr_q;
          ff_vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_cnt_q <= '0;
      ovf_q      <= 1'b0;
      rd_ptr_q   <= '0;
      mm_cnt_q   <= '0;
      ff_idx_q   <= '0;
      ff_vld_q   <= 1'b0;
      sig_q      <= '0;
    end else begin
      load_cnt_q <= load_cnt_d;
      ovf_q      <= ovf_d;
      rd_ptr_q   <= rd_ptr_d;
      mm_cnt_q   <= mm_cnt_d;
      ff_idx_q   <= ff_idx_d;
      ff_vld_q   <= ff_vld_d;
      sig_q      <= sig_d;
    end
  end

  assign mismatch_cnt   = mm_cnt_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_vld = ff_vld_q;
  assign load_cnt       = load_cnt_q;
  assign ovf            = ovf_q;
  assign signature      = sig_q;

endmodule

// File: doc/fsm_response_checker.md
FSM_RESPONSE_CHECKER -- requirements
Module: fsm_response_checker

Interface
REQ-001 SHALL have parameter OUT_LEN, default 19, meaning the width of the fsm output vector under check.
REQ-002 SHALL have parameter DEPTH, default 125, meaning the maximum number of expected vectors stored.
REQ-003 SHALL have parameter IDX_W, default 7, meaning the index/counter width, with 2^IDX_W > DEPTH.
REQ-004 SHALL have parameter POLY, default 19'h00027, meaning the signature feedback polynomial taps.
REQ-005 clk  input  1  sole clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 load_en  input  1  write load_data as the next expected vector.
REQ-008 load_data  input  OUT_LEN  expected fsm output vector.
REQ-009 start  input  1  begin or restart a checking run.
REQ-010 dut_valid  input  1  dut_out holds a sample to check this cycle.
REQ-011 dut_out  input  OUT_LEN  output sampled from the fsm under test.
REQ-012 busy  output  1  high in RUN.
REQ-013 done  output  1  high in DONE.
REQ-014 pass  output  1  done and mismatch_cnt == 0.
REQ-015 mismatch_cnt  output  IDX_W  number of mismatching samples in the current run.
REQ-016 first_fail_idx  output  IDX_W  index of the first mismatching sample.
REQ-017 first_fail_vld  output  1  first_fail_idx is meaningful.
REQ-018 load_cnt  output  IDX_W  number of expected vectors stored.
REQ-019 ovf  output  1  sticky; a load was attempted with load_cnt == DEPTH.
REQ-020 signature  output  OUT_LEN  MISR signature over all checked dut_out samples.

Function
REQ-021 SHALL implement states IDLE, LOAD, RUN, DONE.
REQ-022 IDLE/LOAD: load_en writes load_data to mem[load_cnt], increments load_cnt, and enters LOAD.
REQ-023 load_en with load_cnt == DEPTH SHALL be dropped, leave load_cnt unchanged, and set ovf.
REQ-024 load_en in RUN or DONE SHALL be ignored, with no write and no ovf change.
REQ-025 start in IDLE/LOAD with load_cnt > 0 SHALL enter RUN next cycle and clear rd_ptr, mismatch_cnt, first_fail_vld, first_fail_idx and signature.
REQ-026 start with load_cnt == 0 SHALL be ignored and the state remains IDLE.
REQ-027 load_en and start in the same cycle in IDLE/LOAD: the load SHALL take effect and start SHALL be ignored.
REQ-028 RUN: each cycle with dut_valid = 1 SHALL compare dut_out against mem[rd_ptr] and increment rd_ptr; dut_valid = 0 cycles SHALL change nothing.
REQ-029 A mismatch SHALL increment mismatch_cnt, registered and visible the cycle after the sample; on the first mismatch of a run it SHALL also capture first_fail_idx = rd_ptr and set first_fail_vld.
REQ-030 The signature SHALL update on every valid sample: sig <= {sig[OUT_LEN-2:0],1'b0} ^ (sig[OUT_LEN-1] ? POLY : 0) ^ dut_out.
REQ-031 When the sample at rd_ptr == load_cnt-1 is checked, the block SHALL enter DONE; done and pass SHALL be valid the next cycle and reflect that final sample.
REQ-032 DONE SHALL hold all results until start, which re-runs the stored vectors exactly as in REQ-025; dut_valid in DONE SHALL be ignored.
REQ-033 start in RUN SHALL restart the run as in REQ-025, and that cycle's sample SHALL be discarded.
REQ-034 pass SHALL be 0 in every state other than DONE.

Reset
REQ-035 When rst = 0, the block SHALL immediately go to IDLE with all outputs 0, including load_cnt, ovf and signature.
REQ-036 Stored vectors need no reset but SHALL be unreachable until reloaded.
REQ-037 Reset during RUN SHALL abort the run and discard all partial results.

Verification
REQ-038 Load 125 vectors, start, and feed identical dut_out with dut_valid held high -> done 126 cycles after start, pass = 1, mismatch_cnt = 0.
REQ-039 Load 4 vectors, start, and corrupt samples 1 and 3 -> mismatch_cnt = 2, first_fail_idx = 1, first_fail_vld = 1, pass = 0.
REQ-040 126 loads -> load_cnt = 125, ovf = 1; a following start runs 125 samples.
REQ-041 start with nothing loaded -> remains IDLE with busy = 0; load_en together with start -> load_cnt = 1, busy = 0.
REQ-042 Load 1 vector 19'h00001 and feed 19'h00001 -> signature = 19'h00001; rerun feeding it twice via restart -> signature identical.
REQ-043 rst low mid-RUN with dut_valid gaps -> all outputs 0 asynchronously, state IDLE, load_cnt = 0.
